// File: rtl/utpu_pkg.sv
// Shared uTPU definitions: readback streamer state encoding and frame format.
package utpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_READ,
      ST_WAIT,
      ST_LO,
      ST_HI,
      ST_CSUM,
      ST_DONE
   } streamer_state_e;

   // Frame start marker the host hunts for when resynchronising.
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Bytes wrapped around the payload: one sync byte plus one checksum byte.
   localparam int FRAME_OVERHEAD_BYTES = 2;

endpackage

// File: rtl/result_streamer.sv
// Readback streamer: reads a run of buffer words and emits a framed byte
// stream (sync, low/high payload bytes, XOR checksum) into the TX FIFO.
module result_streamer #(
   parameter int BUFFER_WORD_SIZE = 16,   // must be 2 * FIFO_DATA_WIDTH
   parameter int FIFO_DATA_WIDTH  = 8,
   parameter int ADDRESS_SIZE     = 10,
   parameter int LEN_WIDTH        = 10,
   parameter logic [FIFO_DATA_WIDTH-1:0] SYNC_BYTE = utpu_pkg::SYNC_BYTE
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDRESS_SIZE-1:0]     req_addr,
   input  logic [LEN_WIDTH-1:0]        req_len,
   output logic                        mem_re,
   output logic [ADDRESS_SIZE-1:0]     mem_addr,
   input  logic [BUFFER_WORD_SIZE-1:0] mem_rdata,
   output logic                        fifo_we,
   output logic [FIFO_DATA_WIDTH-1:0]  fifo_wdata,
   input  logic                        fifo_full,
   output logic                        busy,
   output logic                        done
);
   import utpu_pkg::*;

   streamer_state_e               state_q, state_d;
   logic [ADDRESS_SIZE-1:0]       addr_q;
   logic [LEN_WIDTH-1:0]          cnt_q;
   logic [FIFO_DATA_WIDTH-1:0]    csum_q;
   logic [BUFFER_WORD_SIZE-1:0]   word_q;
   logic [FIFO_DATA_WIDTH-1:0]    lo_byte, hi_byte;

   assign lo_byte = word_q[FIFO_DATA_WIDTH-1:0];
   assign hi_byte = word_q[BUFFER_WORD_SIZE-1 -: FIFO_DATA_WIDTH];

   // State register and datapath registers (address, remaining count, checksum, word).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: if (req_valid) begin
               addr_q <= req_addr;
               cnt_q  <= req_len;
               csum_q <= '0;
            end
            ST_WAIT: word_q <= mem_rdata;
            ST_LO:   if (!fifo_full) csum_q <= csum_q ^ lo_byte;
            ST_HI:   if (!fifo_full) begin
               csum_q <= csum_q ^ hi_byte;
               addr_q <= addr_q + ADDRESS_SIZE'(1);   // wraps naturally
               cnt_q  <= cnt_q - LEN_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   // Next-state and output decode; everything is held at 0 while rst is high
   // so a mid-frame reset stops writes in the very cycle it is asserted.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = '0;
      fifo_we    = 1'b0;
      fifo_wdata = '0;
      busy       = 1'b0;
      done       = 1'b0;
      if (!rst) begin
         busy = (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               req_ready = 1'b1;
               if (req_valid) state_d = ST_SYNC;
            end
            ST_SYNC: if (!fifo_full) begin
               fifo_we    = 1'b1;
               fifo_wdata = SYNC_BYTE;
               state_d    = (cnt_q != '0) ? ST_READ : ST_CSUM;
            end
            ST_READ: begin
               mem_re   = 1'b1;
               mem_addr = addr_q;
               state_d  = ST_WAIT;
            end
            ST_WAIT: state_d = ST_LO;
            ST_LO: if (!fifo_full) begin
               fifo_we    = 1'b1;
               fifo_wdata = lo_byte;
               state_d    = ST_HI;
            end
            ST_HI: if (!fifo_full) begin
               fifo_we    = 1'b1;
               fifo_wdata = hi_byte;
               state_d    = (cnt_q == LEN_WIDTH'(1)) ? ST_CSUM : ST_READ;
            end
            ST_CSUM: if (!fifo_full) begin
               fifo_we    = 1'b1;
               fifo_wdata = csum_q;
               state_d    = ST_DONE;
            end
            ST_DONE: begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: frame contents, latency, wrap,
// backpressure, busy rejection and mid-frame reset.
module tb_result_streamer;
   import utpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [9:0]  req_addr = '0;
   logic [9:0]  req_len = '0;
   logic        mem_re;
   logic [9:0]  mem_addr;
   logic [15:0] mem_rdata;
   logic        fifo_we;
   logic [7:0]  fifo_wdata;
   logic        fifo_full = 1'b0;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   result_streamer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len),
      .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .fifo_we(fifo_we), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Buffer model: one-cycle read latency
   logic [15:0] mem [0:1023];
   always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

   // Monitor: logs bytes, read addresses, accepts and done pulses at each edge
   int          cyc = 0;
   int          viol = 0;
   logic [7:0]  byte_log[$];
   logic [9:0]  addr_log[$];
   int          acc_at[$];
   int          done_at[$];
   always @(posedge clk) begin
      if (fifo_we) byte_log.push_back(fifo_wdata);
      if (fifo_we && fifo_full) viol++;
      if (!fifo_we && fifo_wdata != 8'h00) viol++;
      if (mem_re) addr_log.push_back(mem_addr);
      if (req_valid && req_ready) acc_at.push_back(cyc);
      if (done) done_at.push_back(cyc);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bytes(input string tag, input int b0, input logic [7:0] exp[$]);
      chk({tag, "_count"}, byte_log.size() - b0, exp.size());
      for (int i = 0; i < exp.size(); i++)
         if (b0 + i < byte_log.size())
            chk($sformatf("%s_byte%0d", tag, i), byte_log[b0+i], exp[i]);
   endtask

   // One request from the cycle after an edge; returns done latency from accept (-1 on timeout)
   task automatic run_frame(input logic [9:0] a, input logic [9:0] n, input bit bp, output int rel);
      int c;
      int d0;
      d0 = done_at.size();
      req_addr = a; req_len = n; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      c = 1;
      while (done_at.size() == d0 && c < 300) begin
         fifo_full = bp && ((c >= 5 && c <= 9) || (c >= 14 && c <= 18) || (c >= 23 && c <= 27));
         @(posedge clk); #1;
         c++;
      end
      fifo_full = 1'b0;
      rel = (done_at.size() > d0) ? done_at[d0] - acc_at[acc_at.size()-1] : -1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Directed sequence
   initial begin
      logic [7:0] exp[$];
      int rel, b0, a0, d0, q0, ready_bad, c;

      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[10'h010] = 16'hBEEF;
      mem[10'h3FF] = 16'h1234;
      mem[10'h000] = 16'hABCD;
      mem[10'h100] = 16'h0001;
      mem[10'h101] = 16'h8002;
      mem[10'h102] = 16'hFF03;
      mem[10'h020] = 16'h5A3C;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_we",    fifo_we, 0);
      chk("rst_re",    mem_re, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      rst = 1'b0;
      #1;
      chk("rst_ready_after", req_ready, 1);

      // Single word
      b0 = byte_log.size(); a0 = addr_log.size();
      run_frame(10'h010, 10'd1, 1'b0, rel);
      exp = {8'hA5, 8'hEF, 8'hBE, 8'h51};
      chk_bytes("single", b0, exp);
      chk("single_done_lat", rel, 7);
      chk("single_nreads", addr_log.size() - a0, 1);
      if (addr_log.size() > a0) chk("single_addr", addr_log[a0], 10'h010);

      // Zero length
      b0 = byte_log.size(); a0 = addr_log.size();
      run_frame(10'h123, 10'd0, 1'b0, rel);
      exp = {8'hA5, 8'h00};
      chk_bytes("zero", b0, exp);
      chk("zero_done_lat", rel, 3);
      chk("zero_no_read", addr_log.size() - a0, 0);

      // Address wrap
      b0 = byte_log.size(); a0 = addr_log.size();
      run_frame(10'h3FF, 10'd2, 1'b0, rel);
      exp = {8'hA5, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
      chk_bytes("wrap", b0, exp);
      chk("wrap_done_lat", rel, 11);
      chk("wrap_nreads", addr_log.size() - a0, 2);
      if (addr_log.size() > a0 + 1) begin
         chk("wrap_addr0", addr_log[a0], 10'h3FF);
         chk("wrap_addr1", addr_log[a0+1], 10'h000);
      end

      // Backpressure: full for 5 cycles in each HI
      b0 = byte_log.size();
      run_frame(10'h100, 10'd3, 1'b1, rel);
      exp = {8'hA5, 8'h01, 8'h00, 8'h02, 8'h80, 8'h03, 8'hFF, 8'h7F};
      chk_bytes("bp", b0, exp);
      chk("bp_done_lat", rel, 15 + 15);
      chk("bp_frame_len", byte_log.size() - b0, 3 * 2 + FRAME_OVERHEAD_BYTES);

      // Busy rejection: req_valid held through a frame
      d0 = done_at.size(); q0 = acc_at.size(); ready_bad = 0;
      req_addr = 10'h010; req_len = 10'd1; req_valid = 1'b1;
      for (c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (c <= 7 && req_ready) ready_bad++;
         if (c == 1) chk("busy_c1", busy, 1);
         if (c == 7) begin
            chk("busy_done_pulse", done, 1);
            chk("busy_c7", busy, 1);
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      c = 0;
      while (done_at.size() < d0 + 2 && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      chk("busy_ready_low", ready_bad, 0);
      chk("busy_accepts", acc_at.size() - q0, 2);
      if (acc_at.size() >= q0 + 2) chk("busy_next_accept", acc_at[q0+1] - acc_at[q0], 8);
      chk("busy_dones", done_at.size() - d0, 2);

      // Reset at cycle 5 of a len=4 frame
      b0 = byte_log.size(); d0 = done_at.size();
      req_addr = 10'h020; req_len = 10'd4; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("midrst_we", fifo_we, 0);
      chk("midrst_ready", req_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_ready_after", req_ready, 1);
      chk("midrst_busy_after", busy, 0);
      repeat (20) begin @(posedge clk); #1; end
      exp = {8'hA5, 8'h3C};
      chk_bytes("midrst", b0, exp);
      chk("midrst_no_done", done_at.size() - d0, 0);

      chk("drive_rules", viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_streamer.md
# result_streamer

Readback path of the uTPU: on a host request it reads a run of 16-bit words from the unified buffer and packs each word into bytes for the TX FIFO, which feeds the UART transmitter. It is the transmit-side counterpart of the instruction fetch in the controller, which assembles 16-bit words low byte first from the RX FIFO. It emits framed packets (sync byte, payload, XOR checksum) so the host can resynchronise. The controller issues one request per FETCH-type readback and waits for `done`.

## Interface
Parameters:
- `BUFFER_WORD_SIZE`, 16: unified-buffer word width; must equal 2 × `FIFO_DATA_WIDTH`.
- `FIFO_DATA_WIDTH`, 8: TX FIFO byte width.
- `ADDRESS_SIZE`, 10: unified-buffer address width.
- `LEN_WIDTH`, 10: width of the word-count field.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high only in IDLE and while `rst` is low.
- `req_addr`  in  ADDRESS_SIZE  first word address.
- `req_len`  in  LEN_WIDTH  number of words; 0 is legal.
- `mem_re`  out  1  buffer read enable, one-cycle pulse.
- `mem_addr`  out  ADDRESS_SIZE  buffer read address.
- `mem_rdata`  in  BUFFER_WORD_SIZE  read data, valid exactly 1 cycle after `mem_re`.
- `fifo_we`  out  1  TX FIFO write strobe.
- `fifo_wdata`  out  FIFO_DATA_WIDTH  byte to the FIFO.
- `fifo_full`  in  1  TX FIFO full (same-cycle).
- `busy`  out  1  high from accept until `done`, inclusive.
- `done`  out  1  one-cycle pulse at end of frame.

## Operation
- **Frame:** `SYNC_BYTE`, then for each word its low byte followed by its high byte, then `CSUM`.
- **Checksum:** `CSUM` is the XOR of all payload bytes. With `req_len` = 0 the frame is A5, 00.
- **States:** IDLE → SYNC → {READ → WAIT → LO → HI}×N → CSUM → DONE → IDLE.
- **IDLE:**
  - `req_valid && req_ready` latches the address into `addr_q`, the length into `cnt_q`, and clears `csum_q`.
  - Goes to SYNC.
- **SYNC:**
  - If `!fifo_full`, writes `SYNC_BYTE`.
  - Then goes to READ if `cnt_q` ≠ 0, otherwise to CSUM.
- **READ:** `mem_re` = 1 and `mem_addr` = `addr_q`; goes to WAIT.
- **WAIT:** captures `mem_rdata` into `word_q` at the end of the cycle; goes to LO.
- **LO:** if `!fifo_full`, writes `word_q[7:0]`, XORs it into `csum_q`, and goes to HI.
- **HI:** if `!fifo_full`:
  - writes `word_q[15:8]` and XORs it into `csum_q`;
  - `addr_q` +1 and `cnt_q` −1;
  - goes to CSUM if that was the last word, otherwise to READ.
- **CSUM:** if `!fifo_full`, writes `csum_q ^` (0 for this cycle); goes to DONE.
- **DONE:** `done` = 1 for one cycle; goes to IDLE.
- **Address wrap:** `addr_q` wraps modulo 2^ADDRESS_SIZE, so 0x3FF+1 = 0x000.
- **Requests while busy:** ignored, because `req_ready` = 0. No queueing.
- **Drive rules:**
  - `fifo_we` is never asserted while `fifo_full` = 1.
  - `fifo_wdata` holds 0 when `fifo_we` = 0.

## Timing
- **Reset values:** in the cycle after `rst`, all outputs are 0 and the state is IDLE.
- **`req_ready` during reset:** forced to 0 while `rst` is high; it becomes 1 in the first cycle with `rst` low.
- **Unstalled latency (accept at cycle 0):**
  - SYNC write at cycle 1.
  - Word k: `mem_re` at 2+4k, LO write at 4+4k, HI write at 5+4k.
  - CSUM write at 2+4N; `done` at 3+4N.
- **Throughput:** 4 cycles per word, 2 bytes per word.
- **Backpressure:** `fifo_full` stalls SYNC, LO, HI and CSUM in place with no byte lost or duplicated. READ and WAIT never stall.
- **Reset mid-frame:** aborts immediately. No further writes and no `done`. Bytes already written stay in the FIFO; the host discards the frame on bad checksum or timeout.
- **Back-to-back requests:** the earliest next accept is the cycle after DONE.

## Structure
- **Shared package `utpu_pkg`:**
  - `streamer_state_e` (enum logic [2:0]).
  - `SYNC_BYTE` localparam.
  - The frame-format constant shared with the host driver and the future RX-side frame checker.
- **Sub-modules:** none; the checksum, counter and address are inline registers.

## Test plan
- **Single word:** len=1, addr=0x010, mem[0x010]=16'hBEEF, FIFO never full → bytes A5, EF, BE, 51; `done` at cycle 7.
- **Zero length:** len=0 → bytes A5, 00; `done` at cycle 3; `mem_re` never asserted.
- **Wrap-around:** len=2, addr=0x3FF → `mem_addr` sequence 0x3FF, 0x000; 6 bytes total.
- **Backpressure:** len=3 with `fifo_full` held high 5 cycles during each HI → exact 8-byte frame, no `fifo_we` while full, `done` delayed by 15 cycles.
- **Busy rejection and reset:**
  - `req_valid` held high during an active frame → `req_ready` stays 0 and the second frame starts only after DONE.
  - `rst` at cycle 5 of a len=4 frame → `fifo_we` is 0 afterwards, no `done`, and `req_ready` = 1 one cycle after `rst` drops.
